// File: rtl/calc_n_if.sv
// Requester bus for calc_n: per-port command/operand in, per-port response/result out.
// Each flat vector is MSB-first: port 0 occupies the most significant slice.
interface calc_n_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32
);
  logic [NUM_PORTS*4-1:0]      req_cmd_in;
  logic [NUM_PORTS*DATA_W-1:0] req_data_in;
  logic [NUM_PORTS*2-1:0]      out_resp;
  logic [NUM_PORTS*DATA_W-1:0] out_data;

  modport master (output req_cmd_in, req_data_in, input out_resp, out_data);
  modport slave  (input req_cmd_in, req_data_in, output out_resp, out_data);
endinterface

// File: rtl/calc_n.sv
// calc_n: NUM_PORTS two-beat requester ports sharing one registered ALU behind
// a round-robin arbiter. One response per accepted command, visible for one cycle.
module calc_n #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32
) (
  input  logic    c_clk,
  input  logic    reset_n,
  calc_n_if.slave bus
);
  localparam int SHW = $clog2(DATA_W);
  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CAPT = 2'd1, PEND = 2'd2} state_t;

  logic [3:0]        cmd_w   [NUM_PORTS];
  logic [DATA_W-1:0] din_w   [NUM_PORTS];
  state_t            state_q [NUM_PORTS];
  state_t            state_d [NUM_PORTS];
  logic [3:0]        cmd_q   [NUM_PORTS];
  logic [DATA_W-1:0] op1_q   [NUM_PORTS];
  logic [DATA_W-1:0] op2_q   [NUM_PORTS];
  logic [1:0]        resp_q  [NUM_PORTS];
  logic [DATA_W-1:0] res_q   [NUM_PORTS];
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     gnt_idx;
  logic              gnt_vld;
  logic [DATA_W+1:0] alu_out;

  // ALU: returns {resp, data}; unsigned arithmetic, underflow/overflow force data to 0.
  function automatic logic [DATA_W+1:0] alu_f(input logic [3:0] cmd,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    logic [DATA_W:0]   sum;
    logic [1:0]        r;
    logic [DATA_W-1:0] d;
    sum = {1'b0, a} + {1'b0, b};
    r   = 2'd3;
    d   = '0;
    case (cmd)
      4'd1: begin
        if (sum[DATA_W]) r = 2'd2;
        else begin
          r = 2'd1;
          d = sum[DATA_W-1:0];
        end
      end
      4'd2: begin
        if (a < b) r = 2'd2;
        else begin
          r = 2'd1;
          d = a - b;
        end
      end
      4'd5: begin
        r = 2'd1;
        d = a << b[SHW-1:0];
      end
      4'd6: begin
        r = 2'd1;
        d = a >> b[SHW-1:0];
      end
      default: begin
        r = 2'd3;
        d = '0;
      end
    endcase
    return {r, d};
  endfunction

  // Slice the flat request vectors into per-port fields (port 0 in the top bits).
  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      cmd_w[k] = bus.req_cmd_in[NUM_PORTS*4-1-4*k -: 4];
      din_w[k] = bus.req_data_in[NUM_PORTS*DATA_W-1-DATA_W*k -: DATA_W];
    end
  end

  // Round-robin grant: first PEND port found searching upward from the pointer.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    ptr_d   = ptr_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!gnt_vld && state_q[(int'(ptr_q) + i) % NUM_PORTS] == PEND) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'((int'(ptr_q) + i) % NUM_PORTS);
      end
    end
    if (gnt_vld) begin
      if (gnt_idx == PW'(NUM_PORTS - 1)) ptr_d = '0;
      else                               ptr_d = gnt_idx + 1'b1;
    end
  end

  // Per-port next state; commands arriving outside IDLE are dropped.
  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        IDLE:    if (cmd_w[k] != 4'd0) state_d[k] = CAPT;
        CAPT:    state_d[k] = PEND;
        PEND:    if (gnt_vld && gnt_idx == PW'(k)) state_d[k] = IDLE;
        default: state_d[k] = IDLE;
      endcase
    end
  end

  // Control state: port FSMs and arbiter pointer.
  always_ff @(posedge c_clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_PORTS; k++) state_q[k] <= IDLE;
      ptr_q <= '0;
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) state_q[k] <= state_d[k];
      ptr_q <= ptr_d;
    end
  end

  // Operand capture: beat 0 latches cmd/op1, beat 1 latches op2; qualified by state.
  always_ff @(posedge c_clk) begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (state_q[k] == IDLE && cmd_w[k] != 4'd0) begin
        cmd_q[k] <= cmd_w[k];
        op1_q[k] <= din_w[k];
      end
      if (state_q[k] == CAPT) op2_q[k] <= din_w[k];
    end
  end

  assign alu_out = alu_f(cmd_q[gnt_idx], op1_q[gnt_idx], op2_q[gnt_idx]);

  // Output registers: the granted port loads the ALU result, all others return to zero.
  always_ff @(posedge c_clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        resp_q[k] <= '0;
        res_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (gnt_vld && gnt_idx == PW'(k)) begin
          resp_q[k] <= alu_out[DATA_W+1:DATA_W];
          res_q[k]  <= alu_out[DATA_W-1:0];
        end else begin
          resp_q[k] <= '0;
          res_q[k]  <= '0;
        end
      end
    end
  end

  // Pack per-port results back onto the flat response vectors.
  always_comb begin
    bus.out_resp = '0;
    bus.out_data = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      bus.out_resp[NUM_PORTS*2-1-2*k -: 2]                = resp_q[k];
      bus.out_data[NUM_PORTS*DATA_W-1-DATA_W*k -: DATA_W] = res_q[k];
    end
  end
endmodule

// File: tb/tb_calc_n.sv
// Directed self-checking bench for calc_n with NUM_PORTS=4, DATA_W=32.
module tb_calc_n;
  localparam int NP = 4;
  localparam int DW = 32;

  logic c_clk;
  logic reset_n;
  int   n_chk;
  int   n_fail;

  logic [3:0]    cmd_a  [NP];
  logic [DW-1:0] data_a [NP];
  logic [1:0]    resp_a [NP];
  logic [DW-1:0] odat_a [NP];

  calc_n_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus ();

  calc_n #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
    .c_clk   (c_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    c_clk = 1'b0;
    forever #5 c_clk = ~c_clk;
  end

  // Port 0 occupies the most significant slice of each flat vector.
  always_comb begin
    bus.req_cmd_in  = '0;
    bus.req_data_in = '0;
    for (int k = 0; k < NP; k++) begin
      bus.req_cmd_in[NP*4-1-4*k -: 4]     = cmd_a[k];
      bus.req_data_in[NP*DW-1-DW*k -: DW] = data_a[k];
    end
  end

  always_comb begin
    for (int k = 0; k < NP; k++) begin
      resp_a[k] = bus.out_resp[NP*2-1-2*k -: 2];
      odat_a[k] = bus.out_data[NP*DW-1-DW*k -: DW];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < NP; k++) begin
      cmd_a[k]  = 4'd0;
      data_a[k] = '0;
    end
  endtask

  // Single uncontested command on port p; checks exact T+3 latency and one-cycle pulse.
  task automatic do_op(input int p, input logic [3:0] cmd, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [1:0] er, input logic [DW-1:0] ed,
                       input string tag);
    cmd_a[p] = cmd; data_a[p] = a;
    tick();                                   // now T+1
    cmd_a[p] = 4'd0; data_a[p] = b;
    tick();                                   // now T+2
    data_a[p] = '0;
    chk({tag, "_early"}, 64'(resp_a[p]), 64'd0);
    tick();                                   // now T+3
    chk({tag, "_resp"}, 64'(resp_a[p]), 64'(er));
    chk({tag, "_data"}, 64'(odat_a[p]), 64'(ed));
    tick();                                   // now T+4
    chk({tag, "_gone"}, 64'(resp_a[p]), 64'd0);
  endtask

  // All ports issue add (base+k)+(base+k) together; grants expected from port 'first'.
  task automatic burst(input int base, input int first, input string tag);
    for (int k = 0; k < NP; k++) begin
      cmd_a[k] = 4'd1; data_a[k] = DW'(base + k);
    end
    tick();
    for (int k = 0; k < NP; k++) cmd_a[k] = 4'd0;
    tick();
    clear_inputs();
    tick();                                   // now T+3
    for (int i = 0; i < NP; i++) begin
      int p;
      p = (first + i) % NP;
      for (int q = 0; q < NP; q++) begin
        chk($sformatf("%s_c%0d_p%0d_resp", tag, i, q), 64'(resp_a[q]),
            (q == p) ? 64'd1 : 64'd0);
        chk($sformatf("%s_c%0d_p%0d_data", tag, i, q), 64'(odat_a[q]),
            (q == p) ? 64'(2 * (base + q)) : 64'd0);
      end
      tick();
    end
  endtask

  initial begin
    int seen;
    n_chk  = 0;
    n_fail = 0;
    reset_n = 1'b0;

    // Reset held with random inputs
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < NP; k++) begin
        cmd_a[k]  = 4'($urandom);
        data_a[k] = $urandom;
      end
      tick();
    end
    for (int k = 0; k < NP; k++) begin
      chk($sformatf("rst_resp%0d", k), 64'(resp_a[k]), 64'd0);
      chk($sformatf("rst_data%0d", k), 64'(odat_a[k]), 64'd0);
    end
    clear_inputs();
    tick();
    reset_n = 1'b1;
    tick();

    // Reset while port 0 is in CAPT discards the request
    cmd_a[0] = 4'd1; data_a[0] = 32'd5;
    tick();
    cmd_a[0] = 4'd0; data_a[0] = 32'd7; reset_n = 1'b0;
    tick();
    reset_n = 1'b1; data_a[0] = '0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (resp_a[0] != 2'd0 || odat_a[0] != '0) seen++;
      tick();
    end
    chk("rst_midcapt_noresp", 64'(seen), 64'd0);

    // Contention with pointer at 0, then shift pointer to 2 and repeat
    burst(0, 0, "burst0");
    do_op(1, 4'd1, 32'd3, 32'd4, 2'd1, 32'd7, "p1_add");
    burst(10, 2, "burst1");

    // ALU vectors on port 0
    do_op(0, 4'd1, 32'h1, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000, "add_ok");
    do_op(0, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 32'h0, "add_ovf");
    do_op(0, 4'd2, 32'd5, 32'd5, 2'd1, 32'h0, "sub_eq");
    do_op(0, 4'd2, 32'h1, 32'hF, 2'd2, 32'h0, "sub_unf");
    do_op(0, 4'd2, 32'h10, 32'h1, 2'd1, 32'hF, "sub_ok");
    do_op(0, 4'd5, 32'h8000_0001, 32'h21, 2'd1, 32'h2, "shl");
    do_op(0, 4'd6, 32'h8000_0000, 32'd31, 2'd1, 32'h1, "shr");
    do_op(0, 4'd3, 32'd5, 32'd6, 2'd3, 32'h0, "inv3");
    do_op(0, 4'd4, 32'd5, 32'd6, 2'd3, 32'h0, "inv4");
    do_op(0, 4'd15, 32'hFF, 32'h1, 2'd3, 32'h0, "inv15");

    // Protocol on port 2: extra cmds in CAPT/PEND ignored, back-to-back at T+3
    cmd_a[2] = 4'd1; data_a[2] = 32'd2;
    tick();                                   // T+1
    cmd_a[2] = 4'd2; data_a[2] = 32'd3;
    tick();                                   // T+2
    cmd_a[2] = 4'd2; data_a[2] = 32'd9;
    chk("proto_t2_resp", 64'(resp_a[2]), 64'd0);
    tick();                                   // T+3
    chk("proto_t3_resp", 64'(resp_a[2]), 64'd1);
    chk("proto_t3_data", 64'(odat_a[2]), 64'd5);
    cmd_a[2] = 4'd1; data_a[2] = 32'h10;
    tick();                                   // T+4
    chk("proto_t4_resp", 64'(resp_a[2]), 64'd0);
    cmd_a[2] = 4'd0; data_a[2] = 32'h20;
    tick();                                   // T+5
    data_a[2] = '0;
    chk("proto_t5_resp", 64'(resp_a[2]), 64'd0);
    tick();                                   // T+6
    chk("proto_t6_resp", 64'(resp_a[2]), 64'd1);
    chk("proto_t6_data", 64'(odat_a[2]), 64'h30);
    tick();                                   // T+7
    chk("proto_t7_resp", 64'(resp_a[2]), 64'd0);
    tick();
    chk("proto_t8_resp", 64'(resp_a[2]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/calc_n.md
# calc_n

Parametrised successor to the four-port calc1 calculator. It provides NUM_PORTS independent requester ports sharing one registered ALU behind a round-robin arbiter. Data width and port count are generic, and shift commands are added. It sits wherever calc1 sat: requesters drive two-beat commands, and the block returns exactly one response per accepted command.

## Interface
- NUM_PORTS, default 4: number of requester ports, 1–16.
- DATA_W, default 32: operand/result width, power of two, 8–64.
- SHW, default log2(DATA_W): width of the shift-amount field; derived, not overridden.
- c_clk  in  1: sole clock; all logic on rising edge.
- reset_n  in  1: synchronous, active-low reset, sampled on rising c_clk.
- req_cmd_in  in  NUM_PORTS*4: per-port command, port k in bits [4k : 4k+3], bit 0 MSB (MSB-first ordering throughout).
- req_data_in  in  NUM_PORTS*DATA_W: per-port operand, port k in [k*DATA_W : k*DATA_W+DATA_W-1].
- out_resp  out  NUM_PORTS*2: per-port response, port k in [2k : 2k+1].
- out_data  out  NUM_PORTS*DATA_W: per-port result, same slicing as req_data_in.

## Operation
- Commands: 0 no-op, 1 add, 2 subtract, 5 shift left, 6 shift right (logical). All others (3, 4, 7–15) are invalid.
- Responses: 0 none, 1 success, 2 overflow/underflow, 3 invalid command.
- Request protocol per port:
  - beat 0: cmd ≠ 0 with operand1 on data;
  - beat 1 (next cycle): operand2 on data, cmd ignored.
- Per-port state machine:
  - IDLE → CAPT on cmd ≠ 0.
  - CAPT → PEND unconditionally, latching operand2.
  - PEND → IDLE at the edge where that port's result is loaded into its output register.
  - Nonzero cmd in CAPT or PEND is ignored; no response is ever generated for it.
- Arbiter: one grant per cycle among PEND ports, round-robin.
  - Pointer resets to port 0; after a grant it moves to granted port + 1 (mod NUM_PORTS).
  - Search starts at the pointer.
- ALU arithmetic, unsigned DATA_W:
  - Add: carry-out → resp 2, data 0; else resp 1, data = sum mod 2^DATA_W.
  - Subtract: op1 < op2 → resp 2, data 0; op1 = op2 → resp 1, data 0; else resp 1, data = op1 − op2.
  - Shifts: amount = low SHW bits of op2, upper op2 bits ignored; always resp 1; bits shifted out are lost, zeros shifted in.
  - Invalid command: still consumes beat 1 and arbitrates normally; resp 3, data 0.
- Outputs: out_resp/out_data of a port are nonzero for exactly one cycle per accepted command and 0 in every other cycle.

## Timing
- Reset: while reset_n = 0 at an edge, all ports return to IDLE, pointer goes to 0, and all out_resp/out_data become 0 after that edge.
  - Reset mid-operation discards captured and pending requests; no responses are issued for them.
- Latency: with cmd at cycle T and the port uncontested:
  - operand2 is captured at the end of T+1;
  - the port is granted in T+2;
  - the response is visible during T+3, so minimum latency is 3 cycles.
- Contention: a PEND port waits at most NUM_PORTS−1 extra cycles. Worst-case latency is NUM_PORTS+2 cycles.
- Back-to-back requests on one port: a new beat 0 is accepted in the cycle the previous response is visible, i.e. T+3 at the earliest.
  - Peak per-port throughput: one command per 3 cycles.
  - Aggregate throughput: one result per cycle.
- Simultaneous arrival on all ports: responses appear on consecutive cycles in pointer order, starting at the current pointer.
- NUM_PORTS = 1: the arbiter degenerates to a pass-through; latency stays 3.

## Test plan
- Reset: hold reset_n = 0 for 4 cycles with random inputs → all out_resp = 0 and out_data = 0. Then assert cmd on port 0 mid-CAPT and reset → no response ever appears on port 0.
- Add on port 0, DATA_W = 32:
  - 1 + 0x1FFF_FFFF → resp 1, data 0x2000_0000 in cycle T+3.
  - 0xFFFF_FFFF + 1 → resp 2, data 0.
- Subtract:
  - 5 − 5 → resp 1, data 0.
  - 1 − 0xF → resp 2, data 0.
  - 0x10 − 1 → resp 1, data 0xF.
- Shifts and invalid commands:
  - shl 0x8000_0001 by 0x21 (amount 1) → resp 1, data 0x0000_0002.
  - shr 0x8000_0000 by 31 → resp 1, data 1.
  - cmd 3 and cmd 4 → resp 3, data 0.
- Contention with NUM_PORTS = 4: all four ports issue add k + k at the same T, pointer at 0.
  - Ports 0, 1, 2, 3 respond at T+3, T+4, T+5, T+6 with data 0, 2, 4, 6.
  - A repeat all-port burst then starts from the updated pointer.
- Protocol: on port 2, cmd 1 at T, then cmd 2 at T+1 and T+2 → only one response, the add. A new cmd at T+3 is accepted and responds at T+6.
